hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage CPU. It keeps a small destination-register scoreboard for the EX and MEM stages and produces three kinds of control:
- registered select codes for the two 3-to-1 ALU operand multiplexers;
- load-use stall controls for PC, IF/ID and ID/EX;
- taken-branch flush controls.

It sits beside the ID/EX pipeline register and sequences the operand muxes and pipeline-register enables. It carries no datapath values.

## Interface
- `REG_AW`, 5, register-file address width
- `CNT_W`, 16, width of the saturating event counters
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs`, `id_rt` in REG_AW: ID source register numbers.
- `id_use_rs`, `id_use_rt` in 1: ID instruction reads rs / rt.
- `id_dst` in REG_AW: ID destination register.
- `id_reg_write` in 1: ID instruction writes `id_dst`.
- `id_mem_read` in 1: ID instruction is a load.
- `ex_branch_taken` in 1: branch in EX resolved taken this cycle.
- `pc_write` out 1: PC load enable.
- `ifid_write` out 1: IF/ID load enable.
- `ifid_flush` out 1: clear IF/ID to bubble.
- `idex_flush` out 1: load bubble into ID/EX.
- `fwd_a_sel`, `fwd_b_sel` out 2: operand mux selects for the instruction now in EX:
  - 00 = register file
  - 01 = WB result
  - 10 = MEM ALU result
  - 11 is never driven
- `stall_cnt`, `flush_cnt` out CNT_W: saturating counts of stall and flush cycles.

## Operation
- Scoreboard slots, each holding `{valid, dst, reg_write, is_load}`:
  - EX slot: instruction now in EX.
  - MEM slot: instruction now in MEM.
- Hazard on a source `s`: `id_valid` and the matching use bit are set, `s != 0`, the slot is valid with `reg_write=1`, and `slot.dst == s`.
- Load-use stall (`stall`): EX slot has `is_load=1` and has a hazard on rs or rt.
- Flush (`flush`): `ex_branch_taken`.
- Control outputs:
  - `pc_write = ifid_write = ~stall | flush`
  - `ifid_flush = flush`
  - `idex_flush = stall | flush`
- Flush overrides stall. In a flush cycle the stall is discarded, and `stall_cnt` does not increment.
- Forward select for each operand, computed in ID and registered into EX:
  - EX-slot hazard (not load) → 10.
  - Otherwise MEM-slot hazard → 01.
  - Otherwise 00.
  - EX slot takes priority over MEM slot when both match.
- After a load-use stall, the load sits in the MEM slot. The dependent instruction therefore gets 01 next cycle.
- A WB→ID dependency needs no forwarding. The register file is write-before-read.
- Slot update on every clock:
  - MEM slot ← EX slot.
  - EX slot ← ID inputs, or an invalid bubble when `idex_flush` is set or `id_valid=0`.
  - `fwd_*_sel` ← computed selects, or 00 when `idex_flush` is set.
- Counters:
  - `stall_cnt` += 1 on each cycle with `stall & ~flush`.
  - `flush_cnt` += 1 on each flush cycle.
  - Both hold at all-ones.

## Timing
- Reset (`rst_n=0` at a rising edge): both slots invalid; `fwd_a_sel = fwd_b_sel = 00`; both counters 0.
- Just after reset, `pc_write = ifid_write = 1` and `ifid_flush = idex_flush = 0`, unless `ex_branch_taken` is set.
- A reset asserted mid-stall or mid-flush clears state at that edge. Controls return to the run state in the same cycle.
- `stall` and `flush` are combinational from inputs and slot state: zero-cycle latency, valid in the same cycle.
- `fwd_*_sel` are registered: one-cycle latency. They are valid for the whole cycle the instruction occupies EX.
- A load-use stall lasts exactly one cycle per load. The bubble placed in the EX slot cannot cause a second stall.
- Back-to-back taken branches flush on every cycle they are asserted.

## Structure
- The shared pipeline package holds:
  - `fwd_sel_t` codes FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the scoreboard slot struct.
- One sub-module, `hazard_match`: a combinational slot/source comparator, instantiated four times (EX and MEM slot × rs and rt).
- Counters and slots stay inline.

## Test plan
- **ALU→ALU forwarding:** ID1 writes r3, next ID2 reads r3 as rs → no stall; `fwd_a_sel=10` in ID2's EX cycle; `stall_cnt=0`.
- **Distance-2 forwarding:** write r5, one unrelated instruction, then a reader of r5 in rt → `fwd_b_sel=01`; when both slots write r5, `fwd_b_sel=10`.
- **Load-use:** load r7, next instruction reads r7 → one cycle with `pc_write=0`, `ifid_write=0`, `idex_flush=1`; next cycle `fwd_a_sel=01`; `stall_cnt=1`.
- **r0 and unused operands:** producer writes r0, or consumer has `id_use_rs=0` → no stall, selects 00.
- **Branch vs. stall:** `ex_branch_taken=1` in the same cycle as a load-use hazard → `ifid_flush=1`, `idex_flush=1`, `pc_write=1`; `flush_cnt=1`; `stall_cnt` unchanged.
- **Reset mid-operation and saturation:** `rst_n=0` during a stall → at the next edge, selects 00, counters 0, `pc_write=1`. With CNT_W=2 and 5 stalls, `stall_cnt` holds at 3.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg: forwarding select codes, scoreboard slot type and select priority helper
package hazard_fwd_ctrl_pkg;
   localparam int SB_AW = 5;
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;
   typedef struct packed {
      logic             valid;
      logic [SB_AW-1:0] dst;
      logic             reg_write;
      logic             is_load;
   } slot_t;
   // A load in EX cannot forward yet; that case is stalled and bubbled, so it never selects MEM.
   function automatic fwd_sel_t fwd_pick(logic ex_hit, logic ex_load, logic mem_hit);
      return (ex_hit & ~ex_load) ? FWD_MEM : mem_hit ? FWD_WB : FWD_RF;
   endfunction
endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: ID-stage hazard inputs and pipeline control outputs
// master drives the ID-stage fields and branch resolution; slave (the controller) drives
// the enables, flushes, operand selects and event counters.
interface hazard_fwd_ctrl_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] id_dst;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              ex_branch_taken;
   logic              pc_write;
   logic              ifid_write;
   logic              ifid_flush;
   logic              idex_flush;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write, id_mem_read,
             ex_branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
   );
   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write, id_mem_read,
             ex_branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_fwd_ctrl_hazard_match.sv
// hazard_match: flags an ID source register that is written by a scoreboard slot
// Inputs: ID valid, source number and its use bit; slot valid, dst and reg_write. Output: hit.
module hazard_match
   import hazard_fwd_ctrl_pkg::*;
(
   input  logic             id_valid,
   input  logic [SB_AW-1:0] src,
   input  logic             use_src,
   input  logic             slot_valid,
   input  logic [SB_AW-1:0] slot_dst,
   input  logic             slot_reg_write,
   output logic             hit
);
   // r0 is hardwired zero, so it never carries a dependency.
   assign hit = id_valid & use_src & (|src) & slot_valid & slot_reg_write & (slot_dst == src);
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: EX/MEM scoreboard driving load-use stalls, branch flushes and operand forwarding
// Ports: clk, rst_n (sync, active-low), bus (slave): ID-stage fields and branch in;
// PC/IF-ID enables, flushes, registered forward selects and saturating counters out.
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int REG_AW = SB_AW,
   parameter int CNT_W  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   hazard_fwd_ctrl_if.slave bus
);
   slot_t            ex_q, mem_q, ex_d;
   fwd_sel_t         fa_q, fb_q;
   logic [CNT_W-1:0] sc_q, fc_q;
   logic             ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
   logic             stall, flush, bubble;
   hazard_match u_ex_rs (
      .id_valid(bus.id_valid), .src(bus.id_rs[REG_AW-1:0]), .use_src(bus.id_use_rs),
      .slot_valid(ex_q.valid), .slot_dst(ex_q.dst), .slot_reg_write(ex_q.reg_write), .hit(ex_rs_hit)
   );
   hazard_match u_ex_rt (
      .id_valid(bus.id_valid), .src(bus.id_rt[REG_AW-1:0]), .use_src(bus.id_use_rt),
      .slot_valid(ex_q.valid), .slot_dst(ex_q.dst), .slot_reg_write(ex_q.reg_write), .hit(ex_rt_hit)
   );
   hazard_match u_mem_rs (
      .id_valid(bus.id_valid), .src(bus.id_rs[REG_AW-1:0]), .use_src(bus.id_use_rs),
      .slot_valid(mem_q.valid), .slot_dst(mem_q.dst), .slot_reg_write(mem_q.reg_write), .hit(mem_rs_hit)
   );
   hazard_match u_mem_rt (
      .id_valid(bus.id_valid), .src(bus.id_rt[REG_AW-1:0]), .use_src(bus.id_use_rt),
      .slot_valid(mem_q.valid), .slot_dst(mem_q.dst), .slot_reg_write(mem_q.reg_write), .hit(mem_rt_hit)
   );
   assign stall  = ex_q.is_load & (ex_rs_hit | ex_rt_hit);
   assign flush  = bus.ex_branch_taken;
   assign bubble = stall | flush;
   assign ex_d   = (bubble | ~bus.id_valid) ? slot_t'('0)
                 : slot_t'{1'b1, bus.id_dst[REG_AW-1:0], bus.id_reg_write, bus.id_mem_read};
   assign bus.pc_write   = ~stall | flush;
   assign bus.ifid_write = ~stall | flush;
   assign bus.ifid_flush = flush;
   assign bus.idex_flush = bubble;
   assign bus.fwd_a_sel  = fa_q;
   assign bus.fwd_b_sel  = fb_q;
   assign bus.stall_cnt  = sc_q;
   assign bus.flush_cnt  = fc_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         fa_q  <= FWD_RF;
         fb_q  <= FWD_RF;
         sc_q  <= '0;
         fc_q  <= '0;
      end else begin
         mem_q <= ex_q;
         ex_q  <= ex_d;
         fa_q  <= bubble ? FWD_RF : fwd_pick(ex_rs_hit, ex_q.is_load, mem_rs_hit);
         fb_q  <= bubble ? FWD_RF : fwd_pick(ex_rt_hit, ex_q.is_load, mem_rt_hit);
         // A flush discards a coincident stall, so only unflushed stalls are counted.
         if (stall & ~flush & ~&sc_q) sc_q <= sc_q + 1'b1;
         if (flush & ~&fc_q) fc_q <= fc_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed and randomized checks of hazard_fwd_ctrl against a pipeline model
module tb_hazard_fwd_ctrl;
   typedef struct {
      bit v;
      int dst;
      bit rw;
      bit ld;
   } insn_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, br;
   logic [4:0] id_rs, id_rt, id_dst;
   int         checks = 0, failures = 0;
   bit         known = 0;
   insn_t      m_ex, m_mem;
   int         m_fa, m_fb, m_sc, m_fc, m_sc2, m_fc2;
   always #5 clk = ~clk;
   hazard_fwd_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
   hazard_fwd_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus2 ();
   assign bus.id_valid         = id_valid;
   assign bus.id_rs            = id_rs;
   assign bus.id_rt            = id_rt;
   assign bus.id_use_rs        = id_use_rs;
   assign bus.id_use_rt        = id_use_rt;
   assign bus.id_dst           = id_dst;
   assign bus.id_reg_write     = id_reg_write;
   assign bus.id_mem_read      = id_mem_read;
   assign bus.ex_branch_taken  = br;
   assign bus2.id_valid        = id_valid;
   assign bus2.id_rs           = id_rs;
   assign bus2.id_rt           = id_rt;
   assign bus2.id_use_rs       = id_use_rs;
   assign bus2.id_use_rt       = id_use_rt;
   assign bus2.id_dst          = id_dst;
   assign bus2.id_reg_write    = id_reg_write;
   assign bus2.id_mem_read     = id_mem_read;
   assign bus2.ex_branch_taken = br;
   hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   function automatic bit dep(insn_t p, int s, bit u);
      return id_valid && u && s != 0 && p.v && p.rw && p.dst == s;
   endfunction
   // Nearest older producer wins: distance 1 (EX) from the MEM ALU result, distance 2 from WB.
   function automatic int sel(int s, bit u);
      if (dep(m_ex, s, u)) return 2;
      if (dep(m_mem, s, u)) return 1;
      return 0;
   endfunction
   task automatic chk(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", n, act, exp);
      end
   endtask
   task automatic drive(bit v, int rs, bit urs, int rt, bit urt, int dst, bit rw, bit ld, bit b);
      id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
      id_dst = 5'(dst); id_reg_write = rw; id_mem_read = ld; br = b;
   endtask
   task automatic tick();
      bit stall, flush;
      #1;
      stall = m_ex.ld && (dep(m_ex, int'(id_rs), id_use_rs) || dep(m_ex, int'(id_rt), id_use_rt));
      flush = br;
      if (known) begin
         chk("pc_write", int'(bus.pc_write), int'(!stall || flush));
         chk("ifid_write", int'(bus.ifid_write), int'(!stall || flush));
         chk("ifid_flush", int'(bus.ifid_flush), int'(flush));
         chk("idex_flush", int'(bus.idex_flush), int'(stall || flush));
         chk("fwd_a_sel", int'(bus.fwd_a_sel), m_fa);
         chk("fwd_b_sel", int'(bus.fwd_b_sel), m_fb);
         chk("stall_cnt", int'(bus.stall_cnt), m_sc);
         chk("flush_cnt", int'(bus.flush_cnt), m_fc);
         chk("stall_cnt_w2", int'(bus2.stall_cnt), m_sc2);
         chk("flush_cnt_w2", int'(bus2.flush_cnt), m_fc2);
         chk("fwd_a_sel_w2", int'(bus2.fwd_a_sel), m_fa);
      end
      if (!rst_n) begin
         m_ex = '{default: 0}; m_mem = '{default: 0};
         m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
         known = 1;
      end else if (known) begin
         m_fa = (stall || flush) ? 0 : sel(int'(id_rs), id_use_rs);
         m_fb = (stall || flush) ? 0 : sel(int'(id_rt), id_use_rt);
         if (stall && !flush) begin
            m_sc  = (m_sc < 65535) ? m_sc + 1 : m_sc;
            m_sc2 = (m_sc2 < 3) ? m_sc2 + 1 : m_sc2;
         end
         if (flush) begin
            m_fc  = (m_fc < 65535) ? m_fc + 1 : m_fc;
            m_fc2 = (m_fc2 < 3) ? m_fc2 + 1 : m_fc2;
         end
         m_mem = m_ex;
         if (stall || flush || !id_valid) m_ex = '{default: 0};
         else m_ex = '{v: 1'b1, dst: int'(id_dst), rw: id_reg_write, ld: id_mem_read};
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      #1;
      chk("rst_fwd_a", int'(bus.fwd_a_sel), 0);
      chk("rst_fwd_b", int'(bus.fwd_b_sel), 0);
      chk("rst_stall_cnt", int'(bus.stall_cnt), 0);
      chk("rst_flush_cnt", int'(bus.flush_cnt), 0);
      chk("rst_pc_write", int'(bus.pc_write), 1);
      chk("rst_idex_flush", int'(bus.idex_flush), 0);
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
      drive(1, 3, 1, 0, 0, 4, 1, 0, 0); #1;
      chk("alu_no_stall", int'(bus.pc_write), 1);
      tick();
      chk("alu_fwd_a", int'(bus.fwd_a_sel), 2);
      chk("alu_stall_cnt", int'(bus.stall_cnt), 0);
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
      drive(1, 1, 0, 2, 0, 6, 1, 0, 0); tick();
      drive(1, 0, 0, 5, 1, 0, 0, 0, 0); tick();
      chk("dist2_fwd_b", int'(bus.fwd_b_sel), 1);
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick(); tick();
      drive(1, 0, 0, 5, 1, 0, 0, 0, 0); tick();
      chk("both_fwd_b", int'(bus.fwd_b_sel), 2);
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
      drive(1, 7, 1, 0, 0, 8, 1, 0, 0); #1;
      chk("lu_pc_write", int'(bus.pc_write), 0);
      chk("lu_ifid_write", int'(bus.ifid_write), 0);
      chk("lu_idex_flush", int'(bus.idex_flush), 1);
      tick(); #1;
      chk("lu_single_stall", int'(bus.pc_write), 1);
      tick();
      chk("lu_fwd_a", int'(bus.fwd_a_sel), 1);
      chk("lu_stall_cnt", int'(bus.stall_cnt), 1);
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
      drive(1, 0, 1, 0, 1, 9, 1, 0, 0); #1;
      chk("r0_no_stall", int'(bus.pc_write), 1);
      tick();
      chk("r0_fwd_a", int'(bus.fwd_a_sel), 0);
      drive(1, 0, 0, 0, 0, 8, 1, 1, 0); tick();
      drive(1, 8, 0, 0, 0, 9, 1, 0, 0); #1;
      chk("unused_no_stall", int'(bus.pc_write), 1);
      tick();
      chk("unused_fwd_a", int'(bus.fwd_a_sel), 0);
      drive(1, 0, 0, 0, 0, 9, 1, 1, 0); tick();
      drive(1, 9, 1, 0, 0, 10, 1, 0, 1); #1;
      chk("bs_ifid_flush", int'(bus.ifid_flush), 1);
      chk("bs_idex_flush", int'(bus.idex_flush), 1);
      chk("bs_pc_write", int'(bus.pc_write), 1);
      tick();
      chk("bs_flush_cnt", int'(bus.flush_cnt), 1);
      chk("bs_stall_cnt", int'(bus.stall_cnt), 1);
      drive(1, 0, 0, 0, 0, 10, 1, 1, 0); tick();
      drive(1, 10, 1, 0, 0, 11, 1, 0, 0); #1;
      chk("rs_pre_stall", int'(bus.pc_write), 0);
      rst_n = 0; tick(); rst_n = 1; #1;
      chk("rs_fwd_a", int'(bus.fwd_a_sel), 0);
      chk("rs_stall_cnt", int'(bus.stall_cnt), 0);
      chk("rs_flush_cnt", int'(bus.flush_cnt), 0);
      chk("rs_pc_write", int'(bus.pc_write), 1);
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 0, 11, 1, 1, 0); tick();
         drive(1, 11, 1, 0, 0, 12, 1, 0, 0); tick();
      end
      chk("sat_stall_cnt_w2", int'(bus2.stall_cnt), 3);
      chk("sat_stall_cnt", int'(bus.stall_cnt), 5);
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
         rst_n = ($urandom_range(0, 63) != 0);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
